tdm_demux4: RTL and testbench
=============================

// Module: tdm_demux4
// PURPOSE
//  - Receive end of our mux-based TDM link: splits a 1-bit time-division-multiplexed stream back into NCH parallel channel words.
//  - Serial frame = NCH slots, slot k carries channel k, MSB first.
//  - Frame alignment is marked by fsync, which is high on bit 0 of slot 0.
//  - Sits between the serial link pins and the per-channel consumers; paired with the TDM mux transmitter.
// PARAMETERS
//  - NCH    4  number of channels/slots per frame (2..16)
//  - WIDTH  8  data bits per slot (2..32)
// PORTS
//  - clk       in   1          rising-edge clock; din/fsync sampled every edge
//  - rst_n     in   1          asynchronous, active-low reset
//  - din       in   1          serial TDM data
//  - fsync     in   1          frame marker, high on first bit of frame
//  - ch_data   out  NCH*WIDTH  channel k word at [k*WIDTH +: WIDTH]
//  - ch_valid  out  NCH        1-cycle pulse, bit k = ch_data slice k just updated
//  - ch_perr   out  NCH        parity error flag, qualified by ch_valid
//  - locked    out  1          frame alignment held
//  - sync_err  out  1          1-cycle pulse on alignment loss or misalignment
// BEHAVIOUR
//  - Reset: all outputs 0, state HUNT, counters 0; async assert, sync deassert by caller.
//  - Reset mid-frame discards partial words with no ch_valid.
//  - SLEN = WIDTH (+1 with parity). bit_cnt 0..SLEN-1, slot_cnt 0..NCH-1; widths $clog2.
//  - FSM states:
//    - HUNT: din ignored unless fsync=1. On fsync=1, din is bit 0 of slot 0; next state RUN with bit_cnt=1, slot_cnt=0.
//    - RUN: each edge shifts din into slot slot_cnt's shift register. bit_cnt wraps SLEN-1 -> 0 and increments slot_cnt, which wraps NCH-1 -> 0.
//  - locked = 1 exactly while state is RUN (registered). It goes high the cycle after the HUNT fsync.
//  - Last bit of slot k sampled at edge E:
//    - at E+1: ch_data slice k = assembled word and ch_valid[k]=1 for one cycle. Latency is 1 clk.
//    - slice holds until the next completion of slot k.
//  - Expected position = bit_cnt==0 && slot_cnt==0 in RUN.
//    - fsync=1 at expected position: normal, stays RUN.
//    - fsync=0 at expected position: sync_err pulse next cycle, state -> HUNT, bit discarded.
//    - fsync=1 elsewhere: sync_err pulse next cycle, partial slot discarded (no ch_valid). That bit is taken as bit 0 of slot 0 and the state stays RUN (immediate realign).
//  - Completion and fsync on the same edge: the completing word is written and valid before any realign takes effect.
//  - No backpressure; consumers must accept each ch_valid pulse.
// CONFIGURATION
//  - Macro TDM_DEMUX_PARITY_EN.
//    - Defined: each slot has WIDTH data bits followed by 1 even-parity bit (SLEN=WIDTH+1).
//    - Defined: ch_perr[k] is set with ch_valid[k] if XOR(data, parity)!=0 and holds until the next slot-k completion. Data is delivered regardless of the parity result.
//    - Not defined: SLEN=WIDTH, no parity logic, ch_perr tied to 0.
// STRUCTURE
//  - Package tdm_pkg:
//    - typedef enum {HUNT, RUN} tdm_state_t
//    - function slot_len(WIDTH)
//    - localparam FRAME_SYNC_POS=0
//  - Sub-module tdm_slot_shreg, one per channel via generate:
//    - shift enable, load-out strobe
//    - WIDTH-bit shift register, optional parity accumulator
//  - Top level holds the FSM, counters, sync_err and the valid pulse generation.
// TESTING
//  - Reset: hold rst_n=0 with random din/fsync -> all outputs 0, locked=0. Assert rst_n mid-frame -> outputs 0 at once, no ch_valid.
//  - Aligned frame NCH=4, WIDTH=8, words A5,3C,FF,01 with fsync on frame bit 0:
//    - ch_valid pulses 0001,0010,0100,1000, each 1 clk after the slot's last bit.
//    - ch_data = 01_FF_3C_A5.
//    - locked=1 from cycle 2.
//  - Missing fsync on frame 2 start -> sync_err pulse, locked=0. A fresh fsync 5 cycles later -> relock, next frame decodes correctly.
//  - Early fsync at slot 1 bit 3 -> sync_err pulse, no ch_valid[1] for that slot, stays locked. Following frame decodes correctly from the new alignment.
//  - With TDM_DEMUX_PARITY_EN, slot 2 parity bit flipped -> ch_valid[2] with ch_perr[2]=1 and data delivered. Other channels show perr=0.
//  - Back-to-back 100 random frames vs scoreboard model -> no mismatch, zero sync_err.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared types and constants for the TDM receive demux.
// Optional feature macro: TDM_DEMUX_PARITY_EN (adds one even-parity bit per slot).
package tdm_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } tdm_state_t;

  // Frame starts at bit 0 of slot 0; used for both counters.
  localparam int FRAME_SYNC_POS = 0;

`ifdef TDM_DEMUX_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  // Serial bits per slot: data bits plus the optional trailing parity bit.
  function automatic int slot_len(input int width);
    return PARITY_EN ? width + 1 : width;
  endfunction

endpackage

// File: rtl/tdm_slot_shreg.sv
// Per-channel slot assembler: shifts serial data MSB first and latches the
// finished word (and parity check result) on the load strobe.
// Optional feature macro: TDM_DEMUX_PARITY_EN.
module tdm_slot_shreg #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             shift_en_i,
  input  logic             load_i,
  input  logic             din_i,
  output logic [WIDTH-1:0] data_o,
  output logic             perr_o
);

`ifdef TDM_DEMUX_PARITY_EN
  // All WIDTH data bits are held; the last serial bit is parity only.
  logic [WIDTH-1:0] sh_q;

  // Shift data bits; on the parity bit the register already holds the word.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sh_q   <= '0;
      data_o <= '0;
      perr_o <= 1'b0;
    end else begin
      if (load_i) begin
        data_o <= sh_q;
        perr_o <= ^{sh_q, din_i};
      end
      if (shift_en_i) sh_q <= {sh_q[WIDTH-2:0], din_i};
    end
  end
`else
  // Only WIDTH-1 bits are stored; the final bit is taken straight from din.
  logic [WIDTH-2:0] sh_q;
  logic [WIDTH-1:0] word;

  assign word   = {sh_q, din_i};
  assign perr_o = 1'b0;

  // Shift every data bit and capture the word on its last bit.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sh_q   <= '0;
      data_o <= '0;
    end else begin
      if (load_i)     data_o <= word;
      if (shift_en_i) sh_q   <= word[WIDTH-2:0];
    end
  end
`endif

endmodule

// File: rtl/tdm_demux4.sv
// TDM receive demux: frame alignment FSM, bit/slot counters, sync error
// pulse and per-channel valid pulses; one tdm_slot_shreg per channel.
// Optional feature macro: TDM_DEMUX_PARITY_EN.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 din_i,
  input  logic                 fsync_i,
  output logic [NCH*WIDTH-1:0] ch_data_o,
  output logic [NCH-1:0]       ch_valid_o,
  output logic [NCH-1:0]       ch_perr_o,
  output logic                 locked_o,
  output logic                 sync_err_o
);

  localparam int SLEN = slot_len(WIDTH);
  localparam int BW   = $clog2(SLEN);
  localparam int SW   = $clog2(NCH);

  localparam logic [BW-1:0] BIT_LAST  = BW'(SLEN - 1);
  localparam logic [BW-1:0] BIT_SYNC  = BW'(FRAME_SYNC_POS);
  localparam logic [SW-1:0] SLOT_LAST = SW'(NCH - 1);
  localparam logic [SW-1:0] SLOT_SYNC = SW'(FRAME_SYNC_POS);

  tdm_state_t      state_q, state_d;
  logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [SW-1:0]   slot_cnt_q, slot_cnt_d;
  logic [NCH-1:0]  valid_q;
  logic            sync_err_q, sync_err_d;

  logic            last_bit, at_sync;
  logic [BW-1:0]   bit_inc;
  logic [SW-1:0]   slot_inc;
  logic            sh_any, ld_any;
  logic [SW-1:0]   sh_slot;
  logic [NCH-1:0]  sh_en, ld;

  assign last_bit = (bit_cnt_q == BIT_LAST);
  assign at_sync  = (bit_cnt_q == BIT_SYNC) && (slot_cnt_q == SLOT_SYNC);
  assign bit_inc  = last_bit ? '0 : bit_cnt_q + BW'(1);
  assign slot_inc = !last_bit ? slot_cnt_q :
                    (slot_cnt_q == SLOT_LAST) ? '0 : slot_cnt_q + SW'(1);

  // Next state, counters and shift/load steering. A completing word is
  // loaded even when an unexpected fsync realigns on the same edge.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    slot_cnt_d = slot_cnt_q;
    sync_err_d = 1'b0;
    sh_any     = 1'b0;
    ld_any     = 1'b0;
    sh_slot    = slot_cnt_q;
    case (state_q)
      HUNT: begin
        if (fsync_i) begin
          state_d    = RUN;
          bit_cnt_d  = BIT_SYNC + BW'(1);
          slot_cnt_d = SLOT_SYNC;
          sh_any     = 1'b1;
          sh_slot    = SLOT_SYNC;
        end
      end
      RUN: begin
        if (at_sync && !fsync_i) begin
          // Marker missing where expected: drop the bit and re-hunt.
          state_d    = HUNT;
          sync_err_d = 1'b1;
          bit_cnt_d  = '0;
          slot_cnt_d = '0;
        end else begin
          ld_any = last_bit;
          if (fsync_i && !at_sync) begin
            // Marker in the wrong place: abandon the partial slot and
            // treat this bit as the start of a new frame.
            sync_err_d = 1'b1;
            sh_any     = 1'b1;
            sh_slot    = SLOT_SYNC;
            bit_cnt_d  = BIT_SYNC + BW'(1);
            slot_cnt_d = SLOT_SYNC;
          end else begin
            // Parity bits are checked but never shifted into the data.
            sh_any     = !(PARITY_EN && last_bit);
            bit_cnt_d  = bit_inc;
            slot_cnt_d = slot_inc;
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  // FSM, counters and the registered pulse outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= HUNT;
      bit_cnt_q  <= '0;
      slot_cnt_q <= '0;
      valid_q    <= '0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      slot_cnt_q <= slot_cnt_d;
      valid_q    <= ld;
      sync_err_q <= sync_err_d;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_slot
    assign sh_en[k] = sh_any && (sh_slot == SW'(k));
    assign ld[k]    = ld_any && (slot_cnt_q == SW'(k));

    tdm_slot_shreg #(.WIDTH(WIDTH)) u_shreg (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .shift_en_i (sh_en[k]),
      .load_i     (ld[k]),
      .din_i      (din_i),
      .data_o     (ch_data_o[k*WIDTH +: WIDTH]),
      .perr_o     (ch_perr_o[k])
    );
  end

  assign ch_valid_o = valid_q;
  assign sync_err_o = sync_err_q;
  assign locked_o   = (state_q == RUN);

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed plus random frame bench for tdm_demux4. The expectation model is
// frame-level: the bench knows which bit it is sending and what word each
// slot carries, so every valid pulse, data hold value and error flag follows.
module tb_tdm_demux4;

  localparam int NCH   = 4;
  localparam int WIDTH = 8;
`ifdef TDM_DEMUX_PARITY_EN
  localparam int SLEN = WIDTH + 1;
  localparam bit PAR  = 1'b1;
`else
  localparam int SLEN = WIDTH;
  localparam bit PAR  = 1'b0;
`endif
  localparam int FBITS = NCH * SLEN;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 din = 1'b0;
  logic                 fsync = 1'b0;
  logic [NCH*WIDTH-1:0] ch_data;
  logic [NCH-1:0]       ch_valid;
  logic [NCH-1:0]       ch_perr;
  logic                 locked;
  logic                 sync_err;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  logic [NCH-1:0][WIDTH-1:0] exp_data = '0;
  logic [NCH-1:0]            exp_perr = '0;

  always #5 clk = ~clk;

  tdm_demux4 #(.NCH(NCH), .WIDTH(WIDTH)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .din_i      (din),
    .fsync_i    (fsync),
    .ch_data_o  (ch_data),
    .ch_valid_o (ch_valid),
    .ch_perr_o  (ch_perr),
    .locked_o   (locked),
    .sync_err_o (sync_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [NCH-1:0] ev,
                         input logic es, input logic el);
    chk({tag, ".valid"},    64'(ch_valid), 64'(ev));
    chk({tag, ".sync_err"}, 64'(sync_err), 64'(es));
    chk({tag, ".locked"},   64'(locked),   64'(el));
    chk({tag, ".data"},     64'(ch_data),  64'(exp_data));
    chk({tag, ".perr"},     64'(ch_perr),  64'(exp_perr));
  endtask

  // Drive one serial bit, then sample 1 time unit after the edge.
  task automatic tick(input logic d, input logic f);
    din   = d;
    fsync = f;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NCH-1:0][WIDTH-1:0] rand_words();
    logic [NCH-1:0][WIDTH-1:0] w;
    for (int k = 0; k < NCH; k++) w[k] = WIDTH'($urandom);
    return w;
  endfunction

  // Send the first nbits of a frame (fsync on its first bit) and check each
  // cycle: a slot's word shows up with its valid bit right after its last bit.
  task automatic send_frame(input string tag, input logic [NCH-1:0][WIDTH-1:0] w,
                            input logic [NCH-1:0] flip, input int nbits,
                            input logic serr_first);
    int n = 0;
    for (int k = 0; k < NCH; k++) begin
      for (int b = 0; b < SLEN; b++) begin
        logic           bitv;
        logic [NCH-1:0] ev;
        if (n >= nbits) return;
        bitv = (b < WIDTH) ? w[k][WIDTH-1-b] : ((^w[k]) ^ flip[k]);
        tick(bitv, n == 0);
        ev = '0;
        if (b == SLEN - 1) begin
          ev[k]       = 1'b1;
          exp_data[k] = w[k];
          exp_perr[k] = PAR ? flip[k] : 1'b0;
        end
        chk_all(tag, ev, (n == 0) && serr_first, 1'b1);
        n++;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NCH-1:0][WIDTH-1:0] w;

    // Reset held with random inputs: everything stays quiet.
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1'($urandom), 1'($urandom));
      chk_all("reset", '0, 1'b0, 1'b0);
    end
    #2 rst_n = 1'b1;

    // Hunting: data without fsync is ignored.
    for (int i = 0; i < 3; i++) begin
      tick(1'($urandom), 1'b0);
      chk_all("hunt_idle", '0, 1'b0, 1'b0);
    end

    // Aligned frame with the reference words.
    w = {8'h01, 8'hFF, 8'h3C, 8'hA5};
    send_frame("aligned", w, '0, FBITS, 1'b0);
    chk("aligned.word", 64'(ch_data), 64'h01FF3CA5);

    // Missing fsync at the next frame start drops lock.
    w = rand_words();
    tick(w[0][WIDTH-1], 1'b0);
    chk_all("miss_fs", '0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick(1'($urandom), 1'b0);
      chk_all("miss_idle", '0, 1'b0, 1'b0);
    end
    send_frame("relock", rand_words(), '0, FBITS, 1'b0);
    send_frame("relock2", rand_words(), '0, FBITS, 1'b0);

    // Early fsync at slot 1 bit 3: slot 1 is abandoned, lock is kept.
    send_frame("early_pre", rand_words(), '0, SLEN + 3, 1'b0);
    send_frame("early_new", rand_words(), '0, FBITS, 1'b1);
    send_frame("early_next", rand_words(), '0, FBITS, 1'b0);

`ifdef TDM_DEMUX_PARITY_EN
    // Bad parity on slot 2 only; data still delivered.
    w = rand_words();
    send_frame("parity", w, 4'b0100, FBITS, 1'b0);
    chk("parity.slot2", 64'(ch_data[2*WIDTH +: WIDTH]), 64'(w[2]));
    send_frame("parity_clr", rand_words(), '0, FBITS, 1'b0);
`endif

    // Back-to-back random frames.
    for (int f = 0; f < 100; f++) begin
      logic [NCH-1:0] flip;
      flip = PAR ? NCH'($urandom) : '0;
      send_frame("rand", rand_words(), flip, FBITS, 1'b0);
    end

    // Reset mid-frame: outputs clear immediately, partial word is lost.
    send_frame("pre_rst", rand_words(), '0, SLEN + 2, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    exp_data = '0;
    exp_perr = '0;
    chk_all("rst_async", '0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick(1'($urandom), 1'($urandom));
      chk_all("rst_hold", '0, 1'b0, 1'b0);
    end
    #2 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1'($urandom), 1'b0);
      chk_all("rst_idle", '0, 1'b0, 1'b0);
    end
    send_frame("post_rst", rand_words(), '0, FBITS, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
